uart_tx_queue: RTL and testbench
================================

// Module: uart_tx_queue
// PURPOSE
//  Byte FIFO plus pacing FSM sitting directly upstream of UartTop's transmit side.
//  Producers (CPU logic, button handlers, message ROMs) push bytes at clock rate.
//  The block drains them one at a time into UartTop's in_w_data/in_valid, pacing on out_BUSY.
//  This replaces ad-hoc single-byte valid pulses that drop bytes while the UART is busy.
// PARAMETERS
//  ADDR_W   4    FIFO depth = 2**ADDR_W entries (16)
//  BUSY_TO  64   clocks to wait for in_BUSY to rise after a pulse before giving up
// PORTS
//  clk           in   1       system clock (PLL c0 domain)
//  rst_n         in   1       synchronous reset, active-low
//  in_data       in   8       byte to enqueue
//  in_valid      in   1       enqueue strobe; accepted when !out_full
//  in_ovf_clear  in   1       clears out_ovf
//  in_BUSY       in   1       UartTop out_BUSY
//  out_w_data    out  8       byte to UartTop in_w_data
//  out_valid     out  1       1-clock send pulse to UartTop in_valid
//  out_full      out  1       FIFO holds 2**ADDR_W bytes
//  out_empty     out  1       FIFO holds 0 bytes
//  out_level     out  ADDR_W+1  current occupancy
//  out_ovf       out  1       sticky: write attempted while full
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - FIFO is emptied; FSM goes to IDLE.
//   - out_valid=0, out_w_data=0, out_full=0, out_empty=1, out_level=0, out_ovf=0.
//   - Reset mid-transfer aborts the transfer; queued bytes are lost.
//  Push:
//   - in_valid && !out_full writes in_data at the tail.
//   - in_valid && out_full drops the byte and sets out_ovf, even if a pop occurs in the same cycle.
//   - Push and pop in the same cycle: level unchanged.
//   - Pointers are ADDR_W bits and wrap modulo depth; level is ADDR_W+1 bits.
//  FSM states IDLE -> ISSUE -> WAIT_BUSY -> WAIT_IDLE -> IDLE:
//   - IDLE: when !out_empty && !in_BUSY, go to ISSUE.
//   - ISSUE: out_w_data<=head and out_valid<=1 for exactly 1 clock; pop the head; go to WAIT_BUSY.
//   - WAIT_BUSY: go to WAIT_IDLE on in_BUSY=1. If in_BUSY stays 0 for BUSY_TO clocks,
//     go to IDLE and treat the byte as sent.
//   - WAIT_IDLE: go to IDLE on in_BUSY=0.
//  Timing and data rules:
//   - out_w_data holds its value until the next ISSUE.
//   - Latency: byte pushed into an empty FIFO with the UART idle -> out_valid high 2 clocks
//     after the push edge.
//   - Never more than one out_valid per in_BUSY rise/fall cycle.
//  Overflow flag:
//   - out_ovf clears on in_ovf_clear.
//   - in_ovf_clear and an overflowing write in the same cycle: set wins.
// CONFIGURATION
//  `UART_TXQ_CRLF_EN defined:
//   - When the head byte is 0x0A, ISSUE first sends 0x0D without popping and sets a cr_sent flag.
//   - The next ISSUE sends 0x0A, pops it, and clears cr_sent.
//   - cr_sent clears on reset.
//  Undefined: bytes are passed through verbatim; no cr_sent logic is generated.
// STRUCTURE
//  Package uart_pkg:
//   - byte_t (logic [7:0]).
//   - ASCII_CR=8'h0D, ASCII_LF=8'h0A.
//   - txq_state_t enum {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE}.
//  Sub-module uart_sync_fifo (ADDR_W, byte_t):
//   - Ports: push, pop, din, dout (registered head), full, empty, level.
//   - Instanced once; the FSM and ovf/CRLF logic stay in this module.
// TESTING
//  1. Reset: hold rst_n=0 mid-WAIT_IDLE with 5 bytes queued -> next cycle out_empty=1,
//     out_level=0, out_valid=0, state IDLE.
//  2. Single byte: push 0x41, BUSY model rises 1 clk after valid and holds 100 clks ->
//     out_valid pulse 2 clks after push, out_w_data=0x41, one pulse only.
//  3. Burst: push "0123456789" back-to-back -> UART model receives 0x30..0x39 in order;
//     each pulse only after in_BUSY has fallen.
//  4. Overflow: with in_BUSY stuck 1, push 17 bytes -> out_full=1, out_level=16, out_ovf=1;
//     pulse in_ovf_clear -> out_ovf=0.
//  5. Timeout: in_BUSY held 0, push 0x55 -> one pulse, back to IDLE after 64 clks;
//     push 0x56 -> second pulse.
//  6. CRLF (macro on): push 0x0A -> UART receives 0x0D then 0x0A, level 1->0 only after 0x0A.
//     Macro off: only 0x0A is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
// Byte type, ASCII control codes and the pacing FSM state encoding.
package uart_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t ASCII_CR = 8'h0D;
   localparam byte_t ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE} txq_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a head output read straight from the storage flops.
// Pointers wrap modulo 2**ADDR_W; level counts 0..2**ADDR_W.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned ADDR_W = 4,
   parameter type         T      = byte_t
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  T                  din,
   output T                  dout,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   T                  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (level == (ADDR_W+1)'(DEPTH));
   assign empty = (level == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         level <= level + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
      end
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue that paces bytes into UartTop's transmit side using its BUSY flag.
// Define UART_TXQ_CRLF_EN to expand each LF into a CR, LF pair on the wire.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned BUSY_TO = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   input  logic              in_ovf_clear,
   input  logic              in_BUSY,
   output logic [7:0]        out_w_data,
   output logic              out_valid,
   output logic              out_full,
   output logic              out_empty,
   output logic [ADDR_W:0]   out_level,
   output logic              out_ovf
);

   localparam int unsigned CNT_W = $clog2(BUSY_TO + 1);

   txq_state_t       state;
   logic [CNT_W-1:0] to_cnt;
   byte_t            head;
   logic             fifo_push;
   logic             fifo_pop;
`ifdef UART_TXQ_CRLF_EN
   logic             cr_sent;
`endif

   assign fifo_push = in_valid && !out_full;

   uart_sync_fifo #(
      .ADDR_W (ADDR_W),
      .T      (byte_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (in_data),
      .dout  (head),
      .full  (out_full),
      .empty (out_empty),
      .level (out_level)
   );

   // The LF stays at the head while its CR goes out, so it is popped on the second ISSUE.
   always_comb begin
      fifo_pop = 1'b0;
      if (state == ISSUE) begin
`ifdef UART_TXQ_CRLF_EN
         fifo_pop = !(head == ASCII_LF && !cr_sent);
`else
         fifo_pop = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_ovf <= 1'b0;
      end else if (in_valid && out_full) begin
         out_ovf <= 1'b1;
      end else if (in_ovf_clear) begin
         out_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         out_w_data <= '0;
         to_cnt     <= '0;
`ifdef UART_TXQ_CRLF_EN
         cr_sent    <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (!out_empty && !in_BUSY) begin
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               out_valid <= 1'b1;
               to_cnt    <= '0;
               state     <= WAIT_BUSY;
`ifdef UART_TXQ_CRLF_EN
               if (head == ASCII_LF && !cr_sent) begin
                  out_w_data <= ASCII_CR;
                  cr_sent    <= 1'b1;
               end else begin
                  out_w_data <= head;
                  cr_sent    <= 1'b0;
               end
`else
               out_w_data <= head;
`endif
            end
            // A UART that never acknowledges is assumed to have taken the byte.
            WAIT_BUSY: begin
               if (in_BUSY) begin
                  state <= WAIT_IDLE;
               end else if (to_cnt == CNT_W'(BUSY_TO - 1)) begin
                  state <= IDLE;
               end else begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
            end
            WAIT_IDLE: begin
               if (!in_BUSY) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a simple UartTop BUSY model.
// Honours UART_TXQ_CRLF_EN to pick the expected LF expansion.
module tb_uart_tx_queue;
   import uart_pkg::*;

   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned BUSY_TO = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ovf_clear = 1'b0;
   logic              in_BUSY = 1'b0;
   logic [7:0]        out_w_data;
   logic              out_valid;
   logic              out_full;
   logic              out_empty;
   logic [ADDR_W:0]   out_level;
   logic              out_ovf;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // BUSY model: 0 = follows out_valid for 'hold' clocks, 1 = stuck high, 2 = stuck low
   int bmode = 0;
   int hold = 100;
   int busy_left = 0;
   int viol = 0;
   int push_cyc = 0;

   byte_t rx [$];
   int    rx_lvl [$];
   int    rx_cyc [$];

   uart_tx_queue #(
      .ADDR_W  (ADDR_W),
      .BUSY_TO (BUSY_TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ovf_clear (in_ovf_clear),
      .in_BUSY      (in_BUSY),
      .out_w_data   (out_w_data),
      .out_valid    (out_valid),
      .out_full     (out_full),
      .out_empty    (out_empty),
      .out_level    (out_level),
      .out_ovf      (out_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: got time limit expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            if (in_BUSY) viol++;
            rx.push_back(out_w_data);
            rx_lvl.push_back(int'(out_level));
            rx_cyc.push_back(cyc);
         end
         if (!rst_n) begin
            busy_left = 0;
            in_BUSY   = 1'b0;
         end else begin
            case (bmode)
               1: in_BUSY = 1'b1;
               2: in_BUSY = 1'b0;
               default: begin
                  if (out_valid) begin
                     in_BUSY   = 1'b1;
                     busy_left = hold;
                  end else if (busy_left > 0) begin
                     busy_left--;
                     if (busy_left == 0) in_BUSY = 1'b0;
                  end else begin
                     in_BUSY = 1'b0;
                  end
               end
            endcase
         end
      end
   end

   task automatic push_byte(input byte_t b);
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      push_cyc = cyc;
   endtask

   task automatic push_end();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (!(out_empty && !in_BUSY && busy_left == 0) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(tag, 32'(n >= budget), 32'd0);
      repeat (80) @(posedge clk);
      #1;
   endtask

   task automatic clear_rx();
      rx.delete();
      rx_lvl.delete();
      rx_cyc.delete();
      viol = 0;
   endtask

   initial begin
      string digits;
      int    gap;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_wdata", 32'(out_w_data), 32'h00);
      check("rst_full", 32'(out_full), 32'd0);
      check("rst_empty", 32'(out_empty), 32'd1);
      check("rst_level", 32'(out_level), 32'd0);
      check("rst_ovf", 32'(out_ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Reset mid-WAIT_IDLE with 5 bytes queued
      bmode = 0;
      hold  = 100;
      clear_rx();
      for (int i = 0; i < 6; i++) push_byte(byte_t'(8'h60 + i));
      push_end();
      repeat (3) @(posedge clk);
      #1;
      check("mid_level", 32'(out_level), 32'd5);
      check("mid_state", 32'(dut.state), 32'(WAIT_IDLE));
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst2_empty", 32'(out_empty), 32'd1);
      check("rst2_level", 32'(out_level), 32'd0);
      check("rst2_valid", 32'(out_valid), 32'd0);
      check("rst2_state", 32'(dut.state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      clear_rx();
      repeat (10) @(posedge clk);
      #1;
      check("rst2_nopulse", 32'(rx.size()), 32'd0);

      // Single byte, BUSY held 100 clocks
      clear_rx();
      hold = 100;
      push_byte(8'h41);
      push_end();
      repeat (110) @(posedge clk);
      #1;
      check("single_count", 32'(rx.size()), 32'd1);
      if (rx.size() > 0) begin
         check("single_data", 32'(rx[0]), 32'h41);
         check("single_lat", 32'(rx_cyc[0] - push_cyc), 32'd2);
      end

      // Burst "0123456789"
      clear_rx();
      hold   = 5;
      digits = "0123456789";
      for (int i = 0; i < 10; i++) push_byte(byte_t'(digits[i]));
      push_end();
      wait_drain("burst_drain", 2000);
      check("burst_count", 32'(rx.size()), 32'd10);
      for (int i = 0; i < 10; i++) begin
         if (i < rx.size()) check($sformatf("burst_byte%0d", i), 32'(rx[i]), 32'(8'h30 + i));
      end
      check("burst_busy_viol", 32'(viol), 32'd0);

      // Overflow with BUSY stuck high
      bmode = 1;
      clear_rx();
      repeat (2) @(posedge clk);
      for (int i = 0; i < 16; i++) push_byte(byte_t'(8'hA0 + i));
      check("ovf_full", 32'(out_full), 32'd1);
      check("ovf_level16", 32'(out_level), 32'd16);
      check("ovf_pre", 32'(out_ovf), 32'd0);
      push_byte(8'hFF);
      push_end();
      @(posedge clk);
      #1;
      check("ovf_set", 32'(out_ovf), 32'd1);
      check("ovf_level_hold", 32'(out_level), 32'd16);
      @(negedge clk);
      in_ovf_clear = 1'b1;
      @(posedge clk);
      #1;
      check("ovf_clear", 32'(out_ovf), 32'd0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      @(posedge clk);
      #1;
      check("ovf_set_wins", 32'(out_ovf), 32'd1);
      @(negedge clk);
      in_valid     = 1'b0;
      in_ovf_clear = 1'b0;
      bmode = 0;
      hold  = 3;
      wait_drain("ovf_drain", 2000);
      check("ovf_drain_count", 32'(rx.size()), 32'd16);
      if (rx.size() == 16) begin
         check("ovf_first", 32'(rx[0]), 32'hA0);
         check("ovf_last", 32'(rx[15]), 32'hAF);
      end

      // BUSY never rises: timeout releases the FSM
      bmode = 2;
      repeat (2) @(posedge clk);
      clear_rx();
      push_byte(8'h55);
      push_byte(8'h56);
      push_end();
      repeat (200) @(posedge clk);
      #1;
      check("to_count", 32'(rx.size()), 32'd2);
      if (rx.size() == 2) begin
         check("to_first", 32'(rx[0]), 32'h55);
         check("to_second", 32'(rx[1]), 32'h56);
         gap = rx_cyc[1] - rx_cyc[0];
         check("to_gap", 32'(gap >= int'(BUSY_TO) && gap <= int'(BUSY_TO) + 4), 32'd1);
      end

      // LF handling
      bmode = 0;
      hold  = 3;
      repeat (2) @(posedge clk);
      clear_rx();
      push_byte(ASCII_LF);
      push_end();
      wait_drain("lf_drain", 500);
`ifdef UART_TXQ_CRLF_EN
      check("crlf_count", 32'(rx.size()), 32'd2);
      if (rx.size() == 2) begin
         check("crlf_cr", 32'(rx[0]), 32'h0D);
         check("crlf_cr_level", 32'(rx_lvl[0]), 32'd1);
         check("crlf_lf", 32'(rx[1]), 32'h0A);
         check("crlf_lf_level", 32'(rx_lvl[1]), 32'd0);
      end
`else
      check("lf_count", 32'(rx.size()), 32'd1);
      if (rx.size() == 1) begin
         check("lf_data", 32'(rx[0]), 32'h0A);
         check("lf_level", 32'(rx_lvl[0]), 32'd0);
      end
`endif
      check("final_empty", 32'(out_empty), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
